// File: rtl/ring_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ring_ctrl_pkg
//
// Shared types and constants for the ring counter control stage.
//   speed_t        - 2-bit step speed index (0 = slowest)
//   SPEED_STEPS    - number of selectable speeds; the index wraps at this value
//   DB_CYCLES_DEF  - default debounce length (10 ms at 50 MHz)
//   BASE_DIV_DEF   - default tick period at speed 0 (0.5 s at 50 MHz)
//   DIV_W          - width of the tick divider counter
//   tick_term()    - terminal count of the divider for a given speed
// ----------------------------------------------------------------------------
package ring_ctrl_pkg;

    typedef logic [1:0] speed_t;

    localparam int SPEED_STEPS   = 4;
    localparam int DB_CYCLES_DEF = 500000;
    localparam int BASE_DIV_DEF  = 25000000;
    localparam int DIV_W         = 32;

    // Each speed step halves the tick period; the divider wraps at period-1.
    function automatic logic [DIV_W-1:0] tick_term(input logic [DIV_W-1:0] base,
                                                   input speed_t          spd);
        return (base >> spd) - DIV_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
//
// Conditions one raw push-button: two-flop synchronizer, debounce counter
// and a one-cycle pulse on each accepted press (stable 0->1 transition).
// Releases are debounced the same way but produce no pulse.
//
// Ports:
//   mclk   in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   btn    in   raw asynchronous button level, active high
//   press  out  registered one-cycle pulse per accepted press
//
// Parameter:
//   DB_CYCLES  consecutive stable cycles needed to accept a new level (>= 2)
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic mclk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stb;
    logic             stb_q;
    logic [CNT_W-1:0] db_cnt;

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; blocking assignments would let sync2 see this edge's
    // sync1 and collapse the synchronizer into a single flop.
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stb    <= 1'b0;
            stb_q  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            // sync1 may go metastable; only sync2 is used by the logic below.
            sync1 <= btn;
            sync2 <= sync1;

            // Any sample that agrees with the stable level restarts the count,
            // so only an uninterrupted run of DB_CYCLES new samples is accepted.
            if (sync2 != stb) begin
                if (db_cnt == CNT_LAST) begin
                    stb    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end

            stb_q <= stb;
            press <= stb & ~stb_q;
        end
    end

endmodule

// File: rtl/ring_step_ctrl.sv
// ----------------------------------------------------------------------------
// ring_step_ctrl
//
// Control stage for the 8-bit ring counter. Debounces a direction button and
// a speed button, and produces a one-cycle step enable at one of four rates so
// the ring counter can run on mclk instead of a divided clock.
//
// Ports:
//   mclk       in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_dir    in   raw direction button; each press toggles mode
//   btn_speed  in   raw speed button; each press advances speed modulo 4
//   btn_pause  in   raw pause button (RING_STEP_PAUSE_EN only)
//   mode       out  shift direction, 1 = right, 0 = left
//   speed      out  current speed index 0..3
//   step_tick  out  registered one-cycle step enable
//   paused     out  1 while ticking is suspended (RING_STEP_PAUSE_EN only)
//
// Parameters:
//   DB_CYCLES  debounce length in mclk cycles (>= 2)
//   BASE_DIV   tick period at speed 0 in mclk cycles (>= 8); speed n divides
//              it by 2^n
//
// Build option:
//   RING_STEP_PAUSE_EN  adds the pause button; while paused the divider holds
//                       its count and no ticks are issued.
// ----------------------------------------------------------------------------
module ring_step_ctrl
    import ring_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int BASE_DIV  = BASE_DIV_DEF
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       btn_dir,
    input  logic       btn_speed,
`ifdef RING_STEP_PAUSE_EN
    input  logic       btn_pause,
    output logic       paused,
`endif
    output logic       mode,
    output logic [1:0] speed,
    output logic       step_tick
);

    logic             press_dir;
    logic             press_speed;
    logic             hold;
    speed_t           speed_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] term;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .mclk  (mclk),
        .rst   (rst),
        .btn   (btn_dir),
        .press (press_dir)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
        .mclk  (mclk),
        .rst   (rst),
        .btn   (btn_speed),
        .press (press_speed)
    );

`ifdef RING_STEP_PAUSE_EN
    logic press_pause;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .mclk  (mclk),
        .rst   (rst),
        .btn   (btn_pause),
        .press (press_pause)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            paused <= 1'b0;
        end else begin
            paused <= paused ^ press_pause;
        end
    end

    assign hold = paused;
`else
    assign hold = 1'b0;
`endif

    assign speed = speed_q;

    always_comb begin
        term = tick_term(DIV_W'(BASE_DIV), speed_q);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            mode      <= 1'b0;
            speed_q   <= '0;
            div_cnt   <= '0;
            step_tick <= 1'b0;
        end else begin
            mode <= mode ^ press_dir;

            // A speed change restarts the period from zero; otherwise a count
            // already past the new, smaller terminal value would have to wrap
            // the full 32-bit range before the next tick. It takes priority
            // over pause so the restart also applies while paused.
            if (press_speed) begin
                speed_q   <= speed_t'((int'(speed_q) + 1) % SPEED_STEPS);
                div_cnt   <= '0;
                step_tick <= 1'b0;
            end else if (hold) begin
                step_tick <= 1'b0;
            end else if (div_cnt == term) begin
                div_cnt   <= '0;
                step_tick <= 1'b1;
            end else begin
                div_cnt   <= div_cnt + DIV_W'(1);
                step_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ring_step_ctrl
//
// Bench for ring_step_ctrl with DB_CYCLES = 4 and BASE_DIV = 16. A reference
// model keeps the raw button history per edge and decides stable-level changes
// from windows of that history; ticks follow from counting active edges since
// the last restart. The model is compared against the DUT on every falling
// edge, alongside directed checks for latency, tick spacing and reset.
// Build with +define+RING_STEP_PAUSE_EN to also exercise the pause button.
// ----------------------------------------------------------------------------
module tb_ring_step_ctrl;

    localparam int DB   = 4;
    localparam int BASE = 16;
    localparam int HMAX = 16384;
`ifdef RING_STEP_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       mclk      = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_dir   = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_pause = 1'b0;
    logic       mode;
    logic [1:0] speed;
    logic       step_tick;
    logic       dut_paused;

    ring_step_ctrl #(
        .DB_CYCLES (DB),
        .BASE_DIV  (BASE)
    ) u_dut (
        .mclk      (mclk),
        .rst       (rst),
        .btn_dir   (btn_dir),
        .btn_speed (btn_speed),
`ifdef RING_STEP_PAUSE_EN
        .btn_pause (btn_pause),
        .paused    (dut_paused),
`endif
        .mode      (mode),
        .speed     (speed),
        .step_tick (step_tick)
    );

`ifndef RING_STEP_PAUSE_EN
    assign dut_paused = 1'b0;
`endif

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit hist [3][HMAX];     // raw button level seen at each edge (0 dir, 1 speed, 2 pause)
    bit m_stb [3];          // accepted stable level per button
    int m_rise [3];         // edge at which the stable level last rose
    int edge_n   = 0;
    bit m_mode   = 1'b0;
    bit m_paused = 1'b0;
    bit m_tick   = 1'b0;
    int m_speed  = 0;
    int m_active = 0;       // unpaused edges since the last period restart

    task automatic model_step();
        bit btn_v [3];
        bit tog   [3];
        bit all_diff;
        int e;
        edge_n++;
        e = edge_n;
        if (e >= HMAX) begin
            $display("FAIL model_history: edge %0d exceeds history depth", e);
            $fatal(1, "history overflow");
        end
        btn_v = '{btn_dir, btn_speed, btn_pause};
        if (rst) begin
            // Both synchronizer flops clear, so the next two edges see 0.
            for (int b = 0; b < 3; b++) begin
                hist[b][e]   = 1'b0;
                hist[b][e-1] = 1'b0;
                m_stb[b]     = 1'b0;
                m_rise[b]    = -100;
            end
            m_mode   = 1'b0;
            m_speed  = 0;
            m_paused = 1'b0;
            m_tick   = 1'b0;
            m_active = 0;
            return;
        end
        for (int b = 0; b < 3; b++) begin
            // Stable rise at edge m -> press pulse at m+1 -> output at m+2.
            tog[b]     = (m_rise[b] == e - 2);
            hist[b][e] = btn_v[b];
        end
        // Level at edge m reaches the debouncer at edge m+2; a new level is
        // accepted once DB consecutive delivered samples all differ from it.
        for (int b = 0; b < 3; b++) begin
            if (e - 1 - DB >= 0) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (hist[b][e-2-j] == m_stb[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_stb[b] = ~m_stb[b];
                    if (m_stb[b]) m_rise[b] = e;
                end
            end
        end
        if (tog[1]) begin
            m_tick   = 1'b0;
            m_active = 0;
        end else if (m_paused) begin
            m_tick = 1'b0;
        end else begin
            m_active++;
            m_tick = ((m_active % (BASE >> m_speed)) == 0);
        end
        if (tog[0]) m_mode = ~m_mode;
        if (tog[1]) m_speed = (m_speed + 1) % 4;
        if (PAUSE_EN && tog[2]) m_paused = ~m_paused;
    endtask

    always @(posedge mclk) model_step();

    always @(negedge mclk) begin
        if (edge_n > 0) begin
            check("model_mode",   mode,       m_mode);
            check("model_speed",  speed,      m_speed);
            check("model_tick",   step_tick,  m_tick);
            check("model_paused", dut_paused, m_paused);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        bit dir;
        bit spd;
        int hold;
        bit exp_mode;
        int exp_speed;
    } vec_t;

    vec_t vecs [14];
    int   tick_cyc [$];
    int   w;
    int   gap;
    int   prev;
    int   period;

    initial begin
        // Table: button levels held for 'hold' cycles, then outputs checked.
        vecs[0]  = '{1'b1, 1'b0, 12, 1'b0, 0};  // second dir press -> back to 0
        vecs[1]  = '{1'b0, 1'b0, 10, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0,  3, 1'b0, 0};  // bounce: 3 high / 1 low
        vecs[3]  = '{1'b0, 1'b0,  1, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0,  3, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0,  1, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0,  3, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b0,  1, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 10, 1'b1, 0};  // final long high toggles once
        vecs[9]  = '{1'b0, 1'b0, 10, 1'b1, 0};
        vecs[10] = '{1'b0, 1'b1, 12, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b0, 10, 1'b1, 1};
        vecs[12] = '{1'b1, 1'b1, 12, 1'b0, 2};
        vecs[13] = '{1'b0, 1'b0, 10, 1'b0, 2};

        // Reset, then idle for 40 cycles.
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge mclk);
            if (step_tick) tick_cyc.push_back(c);
        end
        check("idle_tick_count", tick_cyc.size(), 2);
        check("idle_tick_first",  (tick_cyc.size() > 0) ? tick_cyc[0] : -1, 16);
        check("idle_tick_second", (tick_cyc.size() > 1) ? tick_cyc[1] : -1, 32);
        check("idle_mode",  mode,  0);
        check("idle_speed", speed, 0);

        // Direction press latency: toggles on the 8th edge (E+7).
        btn_dir = 1'b1;
        repeat (7) @(negedge mclk);
        check("dir_before_e7", mode, 0);
        @(negedge mclk);
        check("dir_at_e7", mode, 1);
        repeat (10) @(negedge mclk);
        check("dir_held_once", mode, 1);
        btn_dir = 1'b0;
        repeat (10) @(negedge mclk);

        // Four speed presses: 1, 2, 3, 0 with periods 8, 4, 2, 16.
        for (int k = 0; k < 4; k++) begin
            prev   = speed;
            period = BASE >> ((k + 1) % 4);
            btn_speed = 1'b1;
            w = 0;
            while (speed == prev && w < 20) begin
                @(negedge mclk);
                w++;
            end
            check("spd_value",       speed, (k + 1) % 4);
            check("spd_latency",     w, 8);
            check("spd_change_tick", step_tick, 0);
            check("spd_change_div",  int'(u_dut.div_cnt), 0);
            btn_speed = 1'b0;
            for (int t = 0; t < 2; t++) begin
                gap = 0;
                do begin
                    @(negedge mclk);
                    gap++;
                end while (!step_tick && gap < 40);
                check("spd_tick_gap", gap, period);
            end
            repeat (10) @(negedge mclk);
        end

        // Table-driven patterns.
        for (int i = 0; i < 14; i++) begin
            btn_dir   = vecs[i].dir;
            btn_speed = vecs[i].spd;
            repeat (vecs[i].hold) @(negedge mclk);
            check($sformatf("vec%0d_mode", i),  mode,  vecs[i].exp_mode);
            check($sformatf("vec%0d_speed", i), speed, vecs[i].exp_speed);
        end

        // Simultaneous presses land on the same edge.
        btn_dir   = 1'b1;
        btn_speed = 1'b1;
        repeat (7) @(negedge mclk);
        check("sim_mode_before",  mode,  0);
        check("sim_speed_before", speed, 2);
        @(negedge mclk);
        check("sim_mode_after",  mode,  1);
        check("sim_speed_after", speed, 3);
        btn_dir   = 1'b0;
        btn_speed = 1'b0;
        repeat (10) @(negedge mclk);

        // Reset mid-debounce with the button released: no toggle afterwards.
        btn_dir = 1'b1;
        repeat (4) @(negedge mclk);
        rst     = 1'b1;
        btn_dir = 1'b0;
        @(negedge mclk);
        rst = 1'b0;
        check("rst_mode",  mode,      0);
        check("rst_speed", speed,     0);
        check("rst_tick",  step_tick, 0);
        repeat (15) @(negedge mclk);
        check("rst_no_toggle", mode, 0);

        // Button held through reset is a fresh press once debounced.
        btn_dir = 1'b1;
        repeat (3) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        repeat (7) @(negedge mclk);
        check("held_rst_before", mode, 0);
        @(negedge mclk);
        check("held_rst_after", mode, 1);
        btn_dir = 1'b0;
        repeat (10) @(negedge mclk);

`ifdef RING_STEP_PAUSE_EN
        // Pause, stay silent for 50 cycles, then resume from the held count.
        gap = 0;
        do begin
            @(negedge mclk);
            gap++;
        end while (!step_tick && gap < 40);
        check("pause_sync_tick", step_tick, 1);
        btn_pause = 1'b1;
        w = 0;
        while (!dut_paused && w < 20) begin
            @(negedge mclk);
            w++;
        end
        check("pause_latency", w, DB + 4);
        btn_pause = 1'b0;
        gap = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge mclk);
            if (step_tick) gap++;
        end
        check("pause_no_ticks", gap, 0);
        check("pause_still",    dut_paused, 1);
        btn_pause = 1'b1;
        w = 0;
        while (dut_paused && w < 20) begin
            @(negedge mclk);
            w++;
        end
        check("resume_latency", w, DB + 4);
        btn_pause = 1'b0;
        gap = 0;
        do begin
            @(negedge mclk);
            gap++;
        end while (!step_tick && gap < 40);
        check("resume_remaining", gap, BASE - (DB + 4));
        repeat (10) @(negedge mclk);
`endif

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 600; s++) begin
            btn_dir   = 1'($urandom_range(0, 1));
            btn_speed = 1'($urandom_range(0, 1));
            btn_pause = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) @(negedge mclk);
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                @(negedge mclk);
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
